// File: rtl/pllseq_pkg.sv
// Shared definitions for the PLL reset/lock sequencer.
//   state_t   - sequencer states (PLLRST, WAITLOCK, STABLE, HOLD, RUN, FAULT)
//   RETRY_W   - width of the retry counter
//   max_int   - elaboration-time helper for sizing the shared timer
package pllseq_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLLRST   = 3'd0,
    WAITLOCK = 3'd1,
    STABLE   = 3'd2,
    HOLD     = 3'd3,
    RUN      = 3'd4,
    FAULT    = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pllseq_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset (both flops clear to 0)
//   d   - asynchronous input
//   q   - synchronized output, two clk edges behind d
module pllseq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the main clock PLL, clocked by the PLL
// reference clock. Pulses the PLL reset, waits for lock, qualifies lock for
// a stable window, holds system reset a little longer and then releases it.
// Lock timeouts and lock drops before RUN retry the PLL reset until the
// retry budget is spent, after which a sticky fault is raised.
//
// Build option:
//   PLLSEQ_AUTO_RELOCK_EN - when defined, losing lock in RUN restarts the
//                           sequence; otherwise it lands in FAULT.
//
// Ports:
//   refclk    in   reference clock
//   rst       in   asynchronous active-high reset
//   locked    in   PLL lock, asynchronous to refclk
//   soft_req  in   single-cycle request to restart the sequence
//   pll_rst   out  drives the PLL reset input
//   sys_rst   out  active-high reset for downstream logic
//   ready     out  high only in RUN
//   fault     out  high only in FAULT
//   retry_cnt out  retries consumed in the current sequence
//
// state    | meaning
// ---------+--------------------------------------------------------
// PLLRST   | PLL held in reset for PLL_RST_CYCLES
// WAITLOCK | PLL released, waiting up to LOCK_TIMEOUT_CYCLES for lock
// STABLE   | lock must stay high for LOCK_STABLE_CYCLES
// HOLD     | lock qualified, sys_rst held SYS_RST_HOLD_CYCLES more
// RUN      | system out of reset
// FAULT    | retries exhausted, PLL parked in reset
module pll_reset_sequencer
  import pllseq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 50,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SYS_RST_HOLD_CYCLES = 16,
  parameter int MAX_RETRIES         = 7
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  input  logic               soft_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int MAX_CYC = max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                   max_int(LOCK_STABLE_CYCLES, SYS_RST_HOLD_CYCLES));
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] T_PLLRST_END  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_TIMEOUT_END = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_STABLE_END  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD_END    = TW'(SYS_RST_HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic          lock_s;
  logic          failure;
  logic          retry_clr;
  logic          retry_inc;
  logic          timer_clr;
  logic          timer_run;
  logic          pll_rst_d;
  logic          sys_rst_d;
  logic          ready_d;
  logic          fault_d;

  pllseq_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // Next-state logic. Lock checks come before timer compares so that a
  // lock drop coinciding with timer expiry is treated as a failure.
  always_comb begin
    next_state = state;
    failure    = 1'b0;
    case (state)
      PLLRST: begin
        if (timer == T_PLLRST_END) next_state = WAITLOCK;
      end
      WAITLOCK: begin
        if (lock_s)                      next_state = STABLE;
        else if (timer == T_TIMEOUT_END) failure    = 1'b1;
      end
      STABLE: begin
        if (!lock_s)                    failure    = 1'b1;
        else if (timer == T_STABLE_END) next_state = HOLD;
      end
      HOLD: begin
        if (!lock_s)                  failure    = 1'b1;
        else if (timer == T_HOLD_END) next_state = RUN;
      end
      RUN: begin
`ifdef PLLSEQ_AUTO_RELOCK_EN
        if (!lock_s) next_state = PLLRST;
`else
        if (!lock_s) next_state = FAULT;
`endif
      end
      FAULT: begin
        next_state = FAULT;
      end
      default: begin
        next_state = PLLRST;
      end
    endcase

    if (failure) begin
      next_state = (retry_cnt == RETRY_MAX) ? FAULT : PLLRST;
    end
    if (soft_req) begin
      next_state = PLLRST;
    end
  end

  // A fresh sequence (from RUN, FAULT or a soft request) starts with a full
  // retry budget; retries triggered by a failure keep counting up.
  assign retry_clr = soft_req ||
                     ((next_state == PLLRST) && ((state == RUN) || (state == FAULT)));
  assign retry_inc = failure && (retry_cnt != RETRY_MAX) && !soft_req;

  // soft_req restarts the PLL reset pulse even when already in PLLRST.
  assign timer_clr = soft_req || (next_state != state);
  // RUN and FAULT have no timed exit, so the timer parks there.
  assign timer_run = (state == PLLRST) || (state == WAITLOCK) ||
                     (state == STABLE) || (state == HOLD);

  // Outputs are decoded from the next state and registered alongside it,
  // so they change on the same edge as the state register.
  always_comb begin
    pll_rst_d = (next_state == PLLRST) || (next_state == FAULT);
    sys_rst_d = (next_state != RUN);
    ready_d   = (next_state == RUN);
    fault_d   = (next_state == FAULT);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= PLLRST;
      timer     <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state <= next_state;

      if (timer_clr)      timer <= '0;
      else if (timer_run) timer <= timer + TW'(1);

      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RETRY_W'(1);

      pll_rst <= pll_rst_d;
      sys_rst <= sys_rst_d;
      ready   <= ready_d;
      fault   <= fault_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Expected outputs are hand-derived edge counts relative to an anchor edge.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       soft_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;

  int cyc = 0;
  int base = 0;
  int total = 0;
  int passed = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .SYS_RST_HOLD_CYCLES (4),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .soft_req  (soft_req),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int k);
    while (cyc < base + k) tick();
  endtask

  function automatic logic [7:0] exp_o(input bit p, input bit s, input bit r,
                                       input bit f, input int rc);
    exp_o = {p, s, r, f, 4'(rc)};
  endfunction

  // Observed/expected vector layout: {pll_rst, sys_rst, ready, fault, retry_cnt[3:0]}
  task automatic chk(input string tag, input logic [7:0] expv);
    logic [7:0] obs;
    obs = {pll_rst, sys_rst, ready, fault, retry_cnt};
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  task automatic soft_pulse();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    base = cyc;
  endtask

  initial begin
    // Reset state, asynchronous assertion before any clock edge
    locked = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset_async", exp_o(1, 1, 0, 0, 0));
    tick();
    tick();
    chk("reset_held", exp_o(1, 1, 0, 0, 0));
    rst = 1'b0;
    base = cyc;

    // Normal bring-up with locked high throughout
    step_to(3);  chk("boot_pllrst_last", exp_o(1, 1, 0, 0, 0));
    step_to(4);  chk("boot_pllrst_fall", exp_o(0, 1, 0, 0, 0));
    step_to(16); chk("boot_before_run",  exp_o(0, 1, 0, 0, 0));
    step_to(17); chk("boot_run",         exp_o(0, 0, 1, 0, 0));

    // Lock loss in RUN: 3 edges from locked fall to sys_rst rise
    locked = 1'b0;
    step_to(19); chk("runloss_edge2", exp_o(0, 0, 1, 0, 0));
    step_to(20);
`ifdef PLLSEQ_AUTO_RELOCK_EN
    chk("runloss_relock_pllrst", exp_o(1, 1, 0, 0, 0));
    locked = 1'b1;
    step_to(36); chk("relock_before_run", exp_o(0, 1, 0, 0, 0));
    step_to(37); chk("relock_run",        exp_o(0, 0, 1, 0, 0));
`else
    chk("runloss_fault", exp_o(1, 1, 0, 1, 0));
    locked = 1'b1;
    step_to(22); chk("runloss_fault_sticky", exp_o(1, 1, 0, 1, 0));
    soft_pulse();
    chk("runloss_soft_pllrst", exp_o(1, 1, 0, 0, 0));
    step_to(16); chk("runloss_soft_before_run", exp_o(0, 1, 0, 0, 0));
    step_to(17); chk("runloss_soft_run",        exp_o(0, 0, 1, 0, 0));
`endif

    // Lock glitch of 3 cycles in the middle of STABLE
    soft_pulse();
    chk("glitch_restart", exp_o(1, 1, 0, 0, 0));
    step_to(7);  chk("glitch_in_stable", exp_o(0, 1, 0, 0, 0));
    locked = 1'b0;
    step_to(9);  chk("glitch_not_seen_yet", exp_o(0, 1, 0, 0, 0));
    step_to(10); chk("glitch_retry_pllrst", exp_o(1, 1, 0, 0, 1));
    locked = 1'b1;
    step_to(13); chk("glitch_pllrst_last", exp_o(1, 1, 0, 0, 1));
    step_to(14); chk("glitch_pllrst_fall", exp_o(0, 1, 0, 0, 1));
    step_to(26); chk("glitch_before_run",  exp_o(0, 1, 0, 0, 1));
    step_to(27); chk("glitch_run",         exp_o(0, 0, 1, 0, 1));

    // Lock never arrives: three pulses, 20-cycle waits, then FAULT
    locked = 1'b0;
    soft_pulse();
    chk("nolock_start",     exp_o(1, 1, 0, 0, 0));
    step_to(3);  chk("nolock_p0_last",  exp_o(1, 1, 0, 0, 0));
    step_to(4);  chk("nolock_w0_start", exp_o(0, 1, 0, 0, 0));
    step_to(23); chk("nolock_w0_last",  exp_o(0, 1, 0, 0, 0));
    step_to(24); chk("nolock_p1_start", exp_o(1, 1, 0, 0, 1));
    step_to(27); chk("nolock_p1_last",  exp_o(1, 1, 0, 0, 1));
    step_to(28); chk("nolock_w1_start", exp_o(0, 1, 0, 0, 1));
    step_to(48); chk("nolock_p2_start", exp_o(1, 1, 0, 0, 2));
    step_to(52); chk("nolock_w2_start", exp_o(0, 1, 0, 0, 2));
    step_to(71); chk("nolock_w2_last",  exp_o(0, 1, 0, 0, 2));
    step_to(72); chk("nolock_fault",    exp_o(1, 1, 0, 1, 2));
    step_to(80); chk("nolock_fault_sticky", exp_o(1, 1, 0, 1, 2));

    // Recovery from FAULT via soft_req
    locked = 1'b1;
    soft_pulse();
    chk("recover_pllrst",     exp_o(1, 1, 0, 0, 0));
    step_to(16); chk("recover_before_run", exp_o(0, 1, 0, 0, 0));
    step_to(17); chk("recover_run",        exp_o(0, 0, 1, 0, 0));

    // Reset asserted in HOLD, then full restart
    soft_pulse();
    step_to(14); chk("midrst_in_hold", exp_o(0, 1, 0, 0, 0));
    #2 rst = 1'b1;
    #1 chk("midrst_async", exp_o(1, 1, 0, 0, 0));
    tick();
    tick();
    chk("midrst_held", exp_o(1, 1, 0, 0, 0));
    rst = 1'b0;
    base = cyc;
    step_to(3);  chk("midrst_pllrst_last", exp_o(1, 1, 0, 0, 0));
    step_to(4);  chk("midrst_pllrst_fall", exp_o(0, 1, 0, 0, 0));
    step_to(16); chk("midrst_before_run",  exp_o(0, 1, 0, 0, 0));
    step_to(17); chk("midrst_run",         exp_o(0, 0, 1, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the main clock PLL, running on the PLL reference clock. It drives the PLL's active-high reset input and consumes the PLL's `locked` output. It holds the system in reset until lock has been stable for a programmed time, then releases a clean system reset. It retries PLL reset on lock timeout and reports a sticky fault once the retry budget is exhausted.

## Interface
Parameters:
- PLL_RST_CYCLES, default 50: length of the `pll_rst` pulse (1 µs at 50 MHz).
- LOCK_TIMEOUT_CYCLES, default 50000: maximum wait for lock after `pll_rst` is released.
- LOCK_STABLE_CYCLES, default 1024: synchronized lock must stay high this long before the hold phase.
- SYS_RST_HOLD_CYCLES, default 16: extra cycles `sys_rst` stays asserted after lock is qualified.
- MAX_RETRIES, default 7: number of PLL reset retries before fault; range 1..15.

Ports:
- refclk  in  1  the single clock (50 MHz reference).
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  PLL lock, asynchronous to `refclk`.
- soft_req  in  1  synchronous single-cycle request to restart the sequence.
- pll_rst  out  1  drives the PLL `rst` input.
- sys_rst  out  1  active-high reset for downstream logic.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  4  retries consumed in the current sequence.

## Operation
- `locked` passes through a 2-flop synchronizer to produce `lock_s`.
- One shared timer, `TW = $clog2(max of all cycle parameters)` bits wide. The timer clears on every state change.
- A "failure" is either a lock timeout or `lock_s` falling in STABLE or HOLD. On failure:
  - if `retry_cnt == MAX_RETRIES`, go to FAULT;
  - otherwise increment `retry_cnt` and go to PLLRST.
- States:
  - PLLRST: `pll_rst=1`, `sys_rst=1`. Leave when `timer == PLL_RST_CYCLES-1`; go to WAITLOCK.
  - WAITLOCK: `pll_rst=0`, `sys_rst=1`. If `lock_s` is high, go to STABLE. Else if `timer == LOCK_TIMEOUT_CYCLES-1`, it is a failure.
  - STABLE: `sys_rst=1`. If `lock_s` is low, it is a failure. Else if `timer == LOCK_STABLE_CYCLES-1`, go to HOLD.
  - HOLD: `sys_rst=1`. If `lock_s` is low, it is a failure. Else if `timer == SYS_RST_HOLD_CYCLES-1`, go to RUN.
  - RUN: `sys_rst=0`, `ready=1`. `retry_cnt` keeps its value as status. Loss of `lock_s` is handled per Configuration.
  - FAULT: `pll_rst=1`, `sys_rst=1`, `fault=1`. The PLL is held in reset. Exit only via `rst` or `soft_req`.
- `soft_req` has top priority in every state: next state is PLLRST, with `retry_cnt=0` and `timer=0`.
- `retry_cnt` clears on every entry to PLLRST that comes from RUN, FAULT, or `soft_req`.

## Timing
- Reset values: state PLLRST, `pll_rst=1`, `sys_rst=1`, `ready=0`, `fault=0`, `retry_cnt=0`, timer 0, synchronizer flops 0.
- All outputs are registered and decoded from the state register. They change on the same edge as the state.
- `locked` to `lock_s` latency is 2 cycles. Lock-loss reaction in RUN is 3 edges from the `locked` fall to the `sys_rst` rise.
- Cycle counts per visit:
  - PLLRST lasts exactly PLL_RST_CYCLES.
  - STABLE lasts LOCK_STABLE_CYCLES.
  - HOLD lasts SYS_RST_HOLD_CYCLES.
  - WAITLOCK lasts at most LOCK_TIMEOUT_CYCLES.
- When lock loss and timer expiry coincide, lock loss wins.
- `rst` asserted mid-sequence returns all registers to reset values immediately (asynchronous). Deassertion is the caller's responsibility to synchronize.

## Configuration
- `PLLSEQ_AUTO_RELOCK_EN`:
  - Defined: loss of `lock_s` in RUN goes to PLLRST with `retry_cnt=0`.
  - Undefined: loss of `lock_s` in RUN goes to FAULT.
- All other behaviour is identical in both builds.

## Structure
- Package `pllseq_pkg`: state enum (PLLRST, WAITLOCK, STABLE, HOLD, RUN, FAULT) and the retry counter width constant (4).
- One sub-module, `pllseq_sync2`: a 2-flop synchronizer with asynchronous reset. It is reused for `locked`.

## Test plan
Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, SYS_RST_HOLD_CYCLES=4, MAX_RETRIES=2.
- Normal bring-up, `locked=1` throughout → `pll_rst` falls after 4 cycles, `ready` rises and `sys_rst` falls 17 edges after `rst` release, `retry_cnt=0`.
- Lock never arrives, `locked=0` → three 4-cycle `pll_rst` pulses separated by 20-cycle waits, then `fault=1`, `pll_rst=1`, `retry_cnt=2`.
- Lock glitch, `locked` low for 3 cycles in the middle of STABLE → failure, `retry_cnt=1`, new `pll_rst` pulse, then normal completion to RUN.
- Lock loss in RUN → `sys_rst` rises 3 edges after the `locked` fall. With `PLLSEQ_AUTO_RELOCK_EN`: PLLRST, then back to RUN. Without it: `fault=1`.
- Recovery: `soft_req` pulse while in FAULT → PLLRST next edge, `retry_cnt=0`, `fault=0`, then RUN.
- Reset mid-operation: `rst` asserted in HOLD → outputs go to reset values immediately, and the full sequence restarts on release.
